mem_wb_load: RTL
================

MEM_WB_LOAD -- requirements
Module: mem_wb_load

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning the number of WAIT cycles without a response before the load is abandoned.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port stall_i, input, 1: pipeline hold from the stall controller.
REQ-005 SHALL have port flush_i, input, 1: pipeline flush; kills the in-flight write.
REQ-006 SHALL have ports mem_wreg_i (1), mem_waddr_i (5) and mem_wdata_i (32), all inputs: the MEM-stage write request, destination register and ALU/store result.
REQ-007 SHALL have ports mem_load_i (1), mem_ld_op_i (3: LB/LBU/LH/LHU/LW) and mem_addr_lo_i (2), all inputs: load flag, load type and effective address bits [1:0].
REQ-008 SHALL have ports mem_inst_i (32, input, instruction word), dmem_rvalid_i (1, input, load response valid) and dmem_rdata_i (32, input, load response word).
REQ-009 SHALL have outputs wb_wreg_o (1), wb_waddr_o (5) and wb_wdata_o (32), which drive the register-file write port and its WB-stage forwarding path.
REQ-010 SHALL have outputs stallreq_o (1, load pending, pipeline must hold), load_timeout_o (1, one-cycle timeout pulse) and wb_inst_o (32, debug, see Configuration).

Function
REQ-011 SHALL implement a state machine with two states, IDLE and WAIT.
REQ-012 IDLE, stall_i=0, mem_load_i=0: SHALL register mem_wreg_i, mem_waddr_i and mem_wdata_i onto the wb_* outputs (1-cycle latency).
REQ-013 IDLE, mem_load_i=1, dmem_rvalid_i=1 in the same cycle: SHALL write the aligned response next cycle with wb_wreg_o=1 and stay in IDLE.
REQ-014 IDLE, mem_load_i=1, dmem_rvalid_i=0: SHALL latch waddr, ld_op and addr_lo, drive wb_wreg_o=0, enter WAIT and assert stallreq_o from the next cycle.
REQ-015 WAIT: SHALL capture the response on the first dmem_rvalid_i=1, drive wb_wreg_o=1 with aligned data next cycle, return to IDLE, and deassert stallreq_o in that same cycle.
REQ-016 WAIT SHALL ignore stall_i; a response is never dropped because of a stall.
REQ-017 Timeout: SHALL count WAIT cycles from 0; when the count reaches TIMEOUT_CYC-1 with no response, it SHALL pulse load_timeout_o for 1 cycle, hold wb_wreg_o=0, return to IDLE and clear the counter.
REQ-018 Alignment is big-endian. LB/LBU SHALL select the byte at offset addr_lo (offset 0 = bits [31:24]). LH/LHU SHALL select the half by addr_lo[1] (0 = [31:16]) and ignore addr_lo[0]. LW SHALL pass all 32 bits and ignore addr_lo.
REQ-019 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend.
REQ-020 IDLE with stall_i=1 SHALL hold all outputs and state unchanged.
REQ-021 flush_i=1 in any state SHALL force wb_wreg_o=0, state IDLE and counter 0 next cycle; flush has priority over dmem_rvalid_i and over the timeout.
REQ-022 wb_wreg_o SHALL be 0 whenever the registered destination is register 0.
REQ-023 An undefined mem_ld_op_i value SHALL be treated as LW.

Reset
REQ-024 rst=1 at a clock edge SHALL set state IDLE, counter 0, and wb_wreg_o, wb_waddr_o, wb_wdata_o, wb_inst_o, stallreq_o and load_timeout_o all to 0.
REQ-025 rst SHALL take priority over flush_i, stall_i and any pending load; a load pending when rst is asserted SHALL be abandoned with no write.

Configuration
REQ-026 Macro WB_DEBUG_INST_EN: when defined, wb_inst_o SHALL carry the instruction word, registered alongside wb_wdata_o and held during WAIT.
REQ-027 When WB_DEBUG_INST_EN is undefined, wb_inst_o SHALL be tied to 0 and no instruction register SHALL be synthesised.

Structure
REQ-028 Load-op encodings, the IDLE/WAIT encodings, ZeroWord, NOPRegAddr, RstEnable and the RegBus/RegAddrBus widths SHALL live in the shared defines package.
REQ-029 Byte/halfword selection and extension SHALL be a combinational sub-module named load_align (inputs ld_op, addr_lo, rdata; output 32-bit word).

Verification
REQ-030 The bench SHALL cover a non-load op: mem_wreg_i=1, waddr=3, wdata=0x0000002C -> next cycle wb_wreg_o=1, wb_waddr_o=3, wb_wdata_o=0x2C, stallreq_o=0.
REQ-031 The bench SHALL cover LB with addr_lo=2 and an immediate response rdata=0x1234F678 -> next cycle wb_wdata_o=0xFFFFFFF6; the same case with LBU -> 0x000000F6.
REQ-032 The bench SHALL cover LH with addr_lo=0 and the response 3 cycles late, rdata=0x8001AAAA -> stallreq_o=1 for 3 cycles, then wb_wdata_o=0xFFFF8001, wb_wreg_o=1, stallreq_o=0.
REQ-033 The bench SHALL cover a timeout with TIMEOUT_CYC=4 and no response -> load_timeout_o pulses once at the 4th WAIT cycle, wb_wreg_o stays 0, state returns to IDLE.
REQ-034 The bench SHALL cover flush_i=1 and dmem_rvalid_i=1 in the same WAIT cycle -> no write (wb_wreg_o=0) and stallreq_o=0 next cycle.
REQ-035 The bench SHALL cover rst=1 mid-WAIT followed by a late response -> all outputs 0 and the late response ignored; and waddr=0 with mem_wreg_i=1 -> wb_wreg_o=0.

Source files
------------

// File: rtl/mem_wb_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_load_pkg
// Brief    : Shared bus widths, reset level, load-op and FSM state encodings
//            for the MEM/WB load writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_wb_load_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic                  RstEnable  = 1'b1;

    // Load types follow the RISC-V funct3 encoding; anything else loads a word.
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_load_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_load_if
// Brief    : MEM-stage request, data-memory response and WB-stage result
//            bundle. master = pipeline side, slave = mem_wb_load.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_wb_load_if;
    import mem_wb_load_pkg::*;

    logic                  stall_i;
    logic                  flush_i;
    logic                  mem_wreg_i;
    logic [RegAddrBus-1:0] mem_waddr_i;
    logic [RegBus-1:0]     mem_wdata_i;
    logic                  mem_load_i;
    logic [2:0]            mem_ld_op_i;
    logic [1:0]            mem_addr_lo_i;
    logic [RegBus-1:0]     mem_inst_i;
    logic                  dmem_rvalid_i;
    logic [RegBus-1:0]     dmem_rdata_i;

    logic                  wb_wreg_o;
    logic [RegAddrBus-1:0] wb_waddr_o;
    logic [RegBus-1:0]     wb_wdata_o;
    logic                  stallreq_o;
    logic                  load_timeout_o;
    logic [RegBus-1:0]     wb_inst_o;

    modport master (
        output stall_i, flush_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
               mem_load_i, mem_ld_op_i, mem_addr_lo_i, mem_inst_i,
               dmem_rvalid_i, dmem_rdata_i,
        input  wb_wreg_o, wb_waddr_o, wb_wdata_o, stallreq_o,
               load_timeout_o, wb_inst_o
    );

    modport slave (
        input  stall_i, flush_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
               mem_load_i, mem_ld_op_i, mem_addr_lo_i, mem_inst_i,
               dmem_rvalid_i, dmem_rdata_i,
        output wb_wreg_o, wb_waddr_o, wb_wdata_o, stallreq_o,
               load_timeout_o, wb_inst_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_wb_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Big-endian byte/halfword selection with sign or zero extension
//            of a data-memory load response (purely combinational).
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mem_wb_load_pkg::*;
(
    input  wire logic [2:0]        ld_op,
    input  wire logic [1:0]        addr_lo,
    input  wire logic [RegBus-1:0] rdata,
    output logic      [RegBus-1:0] word
);

    logic [7:0]  w_byte_sel;
    logic [15:0] w_half_sel;

    // Offset 0 is the most significant byte.
    always_comb begin
        w_byte_sel = rdata[31:24];
        case (addr_lo)
            2'd0:    w_byte_sel = rdata[31:24];
            2'd1:    w_byte_sel = rdata[23:16];
            2'd2:    w_byte_sel = rdata[15:8];
            default: w_byte_sel = rdata[7:0];
        endcase
        w_half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        word = rdata;
        case (ld_op)
            LD_LB:   word = {{24{w_byte_sel[7]}}, w_byte_sel};
            LD_LBU:  word = {24'd0, w_byte_sel};
            LD_LH:   word = {{16{w_half_sel[15]}}, w_half_sel};
            LD_LHU:  word = {16'd0, w_half_sel};
            default: word = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_load.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_load
// Brief    : MEM/WB pipeline register with a blocking load-response wait,
//            timeout and flush. Optional macro WB_DEBUG_INST_EN adds a
//            registered debug copy of the instruction word on wb_inst_o.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_load
    import mem_wb_load_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)(
    input  wire logic   clk,
    input  wire logic   rst,
    mem_wb_load_if.slave bus
);

    localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wb_wreg_q, wb_wreg_d;
    logic [RegAddrBus-1:0] wb_waddr_q, wb_waddr_d;
    logic [RegBus-1:0]     wb_wdata_q, wb_wdata_d;
    logic                  timeout_q, timeout_d;
    logic [RegAddrBus-1:0] pend_waddr_q, pend_waddr_d;
    logic [2:0]            pend_op_q, pend_op_d;
    logic [1:0]            pend_lo_q, pend_lo_d;

    logic [2:0]            w_al_op;
    logic [1:0]            w_al_lo;
    logic [RegBus-1:0]     w_aligned;

    // A single aligner serves both the same-cycle hit and the late response.
    assign w_al_op = (state_q == WAIT) ? pend_op_q : bus.mem_ld_op_i;
    assign w_al_lo = (state_q == WAIT) ? pend_lo_q : bus.mem_addr_lo_i;

    load_align u_load_align (
        .ld_op   (w_al_op),
        .addr_lo (w_al_lo),
        .rdata   (bus.dmem_rdata_i),
        .word    (w_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_wreg_q    <= 1'b0;
            wb_waddr_q   <= NOPRegAddr;
            wb_wdata_q   <= ZeroWord;
            timeout_q    <= 1'b0;
            pend_waddr_q <= NOPRegAddr;
            pend_op_q    <= 3'd0;
            pend_lo_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_wreg_q    <= wb_wreg_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
            timeout_q    <= timeout_d;
            pend_waddr_q <= pend_waddr_d;
            pend_op_q    <= pend_op_d;
            pend_lo_q    <= pend_lo_d;
        end
    end

    // The timeout flag defaults low so it stays a single-cycle pulse even
    // when a stall freezes the rest of the outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wb_wreg_d    = wb_wreg_q;
        wb_waddr_d   = wb_waddr_q;
        wb_wdata_d   = wb_wdata_q;
        timeout_d    = 1'b0;
        pend_waddr_d = pend_waddr_q;
        pend_op_d    = pend_op_q;
        pend_lo_d    = pend_lo_q;

        if (bus.flush_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            wb_wreg_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.stall_i) begin
                        if (!bus.mem_load_i) begin
                            wb_wreg_d  = bus.mem_wreg_i && (bus.mem_waddr_i != NOPRegAddr);
                            wb_waddr_d = bus.mem_waddr_i;
                            wb_wdata_d = bus.mem_wdata_i;
                        end else if (bus.dmem_rvalid_i) begin
                            wb_wreg_d  = (bus.mem_waddr_i != NOPRegAddr);
                            wb_waddr_d = bus.mem_waddr_i;
                            wb_wdata_d = w_aligned;
                        end else begin
                            wb_wreg_d    = 1'b0;
                            pend_waddr_d = bus.mem_waddr_i;
                            pend_op_d    = bus.mem_ld_op_i;
                            pend_lo_d    = bus.mem_addr_lo_i;
                            cnt_d        = '0;
                            state_d      = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.dmem_rvalid_i) begin
                        wb_wreg_d  = (pend_waddr_q != NOPRegAddr);
                        wb_waddr_d = pend_waddr_q;
                        wb_wdata_d = w_aligned;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        wb_wreg_d = 1'b0;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.wb_wreg_o      = wb_wreg_q;
    assign bus.wb_waddr_o     = wb_waddr_q;
    assign bus.wb_wdata_o     = wb_wdata_q;
    assign bus.stallreq_o     = (state_q == WAIT);
    assign bus.load_timeout_o = timeout_q;

`ifdef WB_DEBUG_INST_EN
    logic [RegBus-1:0] wb_inst_q, wb_inst_d;

    // Tracks the word register: updates only when IDLE accepts a new op.
    always_comb begin
        wb_inst_d = wb_inst_q;
        if (!bus.flush_i && (state_q == IDLE) && !bus.stall_i) begin
            wb_inst_d = bus.mem_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_inst_q <= ZeroWord;
        end else begin
            wb_inst_q <= wb_inst_d;
        end
    end

    assign bus.wb_inst_o = wb_inst_q;
`else
    wire unused_inst = ^bus.mem_inst_i;

    assign bus.wb_inst_o = ZeroWord;
`endif

endmodule
`default_nettype wire
